// File: rtl/iir_coeff_pkg.sv
// Shared constants, sizing helpers and FSM state type for the IIR coefficient loader.
package iir_coeff_pkg;

  localparam int ORD_DEF      = 10;
  localparam int COEFF_WH_DEF = 2;
  localparam int COEFF_FR_DEF = 15;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  // Three biquad coefficients per second-order section.
  function automatic int calc_ncoeff(input int ord);
    return ord / 2 * 3;
  endfunction

  localparam int NCOEFF_DEF  = calc_ncoeff(ORD_DEF);
  localparam int AW_DEF      = $clog2(NCOEFF_DEF);
  localparam int COEFF_W_DEF = COEFF_WH_DEF + COEFF_FR_DEF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    WRITE   = 3'd4
  } loader_state_e;

endpackage

// File: rtl/iir_coeff_buf.sv
// Staging register file for one complete coefficient set: one write port, one async read port.
module iir_coeff_buf #(
  parameter int N  = 15,
  parameter int W  = 17,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The write burst pre-fetches one past the last index; return zero there.
  assign rdata = (int'(raddr) < N) ? mem[raddr] : '0;

endmodule

// File: rtl/iir_coeff_loader.sv
// Receives a framed, checksummed coefficient stream and bursts the verified set into the filter.
module iir_coeff_loader
  import iir_coeff_pkg::*;
#(
  parameter int ORD      = ORD_DEF,
  parameter int COEFF_WH = COEFF_WH_DEF,
  parameter int COEFF_FR = COEFF_FR_DEF,
  parameter int NCOEFF   = calc_ncoeff(ORD),
  parameter int AW       = $clog2(NCOEFF),
  parameter int COEFF_W  = COEFF_WH + COEFF_FR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               c_we,
  output logic [AW-1:0]      c_addr,
  output logic [COEFF_W-1:0] c_in,
  output logic               busy,
  output logic               done,
  output logic               err,
  output loader_state_e      state
);

  // Stream handshake: a byte moves on a rising edge where s_valid && s_ready;
  // s_ready is registered and high only in HDR, PAYLOAD and CSUM.

  localparam logic [AW-1:0] LAST_IDX = AW'(NCOEFF - 1);

  logic               xfer;
  logic [1:0]         byte_cnt;
  logic [AW-1:0]      idx;
  logic [7:0]         sum;
  logic [7:0]         csum_total;
  logic [15:0]        asm_q;
  logic               buf_we;
  logic [COEFF_W-1:0] buf_wdata;
  logic [AW-1:0]      rd_addr;
  logic [COEFF_W-1:0] rdata;

  assign xfer       = s_valid && s_ready;
  assign csum_total = sum + s_data;
  assign buf_we     = (state == PAYLOAD) && xfer && !abort && (byte_cnt == 2'd2);
  // Little-endian: the third byte is the top of the word; excess high bits drop out.
  assign buf_wdata  = COEFF_W'({s_data, asm_q});
  assign rd_addr    = c_we ? (c_addr + AW'(1)) : '0;

  iir_coeff_buf #(
    .N  (NCOEFF),
    .W  (COEFF_W),
    .AW (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (idx),
    .wdata (buf_wdata),
    .raddr (rd_addr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      s_ready  <= 1'b0;
      c_we     <= 1'b0;
      c_addr   <= '0;
      c_in     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      byte_cnt <= '0;
      idx      <= '0;
      sum      <= '0;
      asm_q    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HDR;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            byte_cnt <= '0;
            idx      <= '0;
            sum      <= '0;
          end
        end
        HDR: begin
          if (abort) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (xfer && (s_data == HDR_BYTE)) begin
            state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (abort) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (xfer) begin
            sum   <= sum + s_data;
            asm_q <= {s_data, asm_q[15:8]};
            if (byte_cnt == 2'd2) begin
              byte_cnt <= '0;
              idx      <= idx + AW'(1);
              if (idx == LAST_IDX) state <= CSUM;
            end else begin
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        CSUM: begin
          if (abort) begin
            state   <= IDLE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
          end else if (xfer) begin
            s_ready <= 1'b0;
            if (csum_total == 8'd0) begin
              state  <= WRITE;
              c_we   <= 1'b1;
              c_addr <= '0;
              c_in   <= rdata;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (c_addr == LAST_IDX) begin
            state <= IDLE;
            c_we  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            c_addr <= rd_addr;
            c_in   <= rdata;
          end
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          c_we    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader: table of frame vectors plus hand-written abort/WRITE/reset sequences.
`timescale 1ns/1ps
module tb_iir_coeff_loader;
  import iir_coeff_pkg::*;

  localparam int N  = NCOEFF_DEF;
  localparam int AW = AW_DEF;
  localparam int W  = COEFF_W_DEF;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [W-1:0]  c_in;
  logic          busy;
  logic          done;
  logic          err;
  loader_state_e state;

  iir_coeff_loader dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_in    (c_in),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .state   (state)
  );

  always #5 clk = ~clk;

  int n_checks    = 0;
  int n_errors    = 0;
  int writes_seen = 0;
  int err_seen    = 0;
  int done_seen   = 0;

  logic [AW+W-1:0] exp_q[$];

  typedef struct {
    string      name;
    logic [16:0] base;
    logic [6:0]  pad;
    int          garbage;
    bit          gapped;
    logic [7:0]  csum_delta;
    bit          exp_err;
    int          exp_writes;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] garb[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (c_we) begin
      logic [AW+W-1:0] e;
      writes_seen++;
      check("write_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("write_addr", 32'(c_addr), 32'(e[AW+W-1:W]));
        check("write_data", 32'(c_in), 32'(e[W-1:0]));
      end
    end
    if (err)  err_seen++;
    if (done) done_seen++;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  // Entered and left at posedge+1.
  task automatic send_byte(input logic [7:0] b, input bit gapped, input bit with_abort);
    bit ok;
    ok = 1'b0;
    if (gapped) begin
      s_valid = 1'b0;
      @(negedge clk);
      check("ready_in_gap", 32'(s_ready), 32'd1);
      @(posedge clk); #1;
    end
    s_data  = b;
    s_valid = 1'b1;
    abort   = with_abort;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    abort   = 1'b0;
    check("byte_accepted", 32'(ok), 32'd1);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("start_ready", 32'(s_ready), 32'd1);
    check("start_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
  endtask

  // mode 0: plain; 1: abort+start during WRITE; 2: rst at the 5th write.
  task automatic run_frame(input vec_t v, input int mode);
    logic [7:0]  bytes[$];
    logic [7:0]  sum;
    logic [7:0]  csum;
    logic [16:0] val;
    int err0, done0, wr0;
    bit stopped;
    sum = 8'd0;
    stopped = 1'b0;
    for (int k = 0; k < N; k++) begin
      val = v.base + 17'(k);
      bytes.push_back(val[7:0]);
      bytes.push_back(val[15:8]);
      bytes.push_back({v.pad, val[16]});
      if (!v.exp_err) exp_q.push_back({AW'(k), val});
    end
    foreach (bytes[j]) sum = sum + bytes[j];
    csum  = (8'd0 - sum) + v.csum_delta;
    err0  = err_seen;
    done0 = done_seen;
    wr0   = writes_seen;

    pulse_start();
    for (int g = 0; g < v.garbage; g++) send_byte(garb[g], v.gapped, 1'b0);
    send_byte(HDR_BYTE, v.gapped, 1'b0);
    foreach (bytes[j]) send_byte(bytes[j], v.gapped, 1'b0);
    send_byte(csum, v.gapped, 1'b0);

    // Now in the cycle right after the checksum edge.
    for (int i = 1; i <= N + 2 && !stopped; i++) begin
      @(negedge clk);
      if (v.exp_err) begin
        if (i == 1) begin
          check({v.name, "_err_pulse"}, 32'(err), 32'd1);
          check({v.name, "_err_ready"}, 32'(s_ready), 32'd0);
          check({v.name, "_err_busy"}, 32'(busy), 32'd0);
          check({v.name, "_err_state"}, 32'(state), 32'(IDLE));
        end
        if (i == 2) check({v.name, "_err_single"}, 32'(err), 32'd0);
      end else begin
        if (i <= N) check({v.name, "_we_run"}, 32'(c_we), 32'd1);
        if (i == 1) begin
          check({v.name, "_first_addr"}, 32'(c_addr), 32'd0);
          check({v.name, "_write_ready"}, 32'(s_ready), 32'd0);
          check({v.name, "_write_busy"}, 32'(busy), 32'd1);
        end
        if (i == N) check({v.name, "_last_addr"}, 32'(c_addr), 32'(N - 1));
        if (mode == 1 && i == 2) begin
          abort = 1'b1;
          start = 1'b1;
        end
        if (mode == 1 && i == 3) begin
          abort = 1'b0;
          start = 1'b0;
        end
        if (mode == 2 && i == 5) begin
          #2 rst = 1'b1;
          #1;
          check("rst_c_we", 32'(c_we), 32'd0);
          check("rst_c_addr", 32'(c_addr), 32'd0);
          check("rst_c_in", 32'(c_in), 32'd0);
          check("rst_s_ready", 32'(s_ready), 32'd0);
          check("rst_busy", 32'(busy), 32'd0);
          check("rst_done", 32'(done), 32'd0);
          check("rst_err", 32'(err), 32'd0);
          check("rst_state", 32'(state), 32'(IDLE));
          exp_q.delete();
          @(posedge clk);
          @(posedge clk); #3;
          check("rst_held_c_we", 32'(c_we), 32'd0);
          rst = 1'b0;
          stopped = 1'b1;
        end
        if (i == N + 1) begin
          check({v.name, "_done"}, 32'(done), 32'd1);
          check({v.name, "_done_busy"}, 32'(busy), 32'd0);
          check({v.name, "_done_we"}, 32'(c_we), 32'd0);
          check({v.name, "_done_state"}, 32'(state), 32'(IDLE));
        end
        if (i == N + 2) check({v.name, "_done_single"}, 32'(done), 32'd0);
      end
    end

    if (stopped) begin
      repeat (20) @(negedge clk);
      check("rst_no_done", 32'(done_seen - done0), 32'd0);
      check("rst_no_err", 32'(err_seen - err0), 32'd0);
      check("rst_write_count", 32'(writes_seen - wr0), 32'd5);
    end else begin
      check({v.name, "_write_count"}, 32'(writes_seen - wr0), 32'(v.exp_writes));
      check({v.name, "_err_count"}, 32'(err_seen - err0), 32'(v.exp_err));
      check({v.name, "_done_count"}, 32'(done_seen - done0), 32'(!v.exp_err));
      check({v.name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int err0, wr0;
    garb[0] = 8'h00;
    garb[1] = 8'hFF;
    garb[2] = 8'h5A;
    vecs[0] = '{"nominal",  17'h00100, 7'h00, 0, 1'b0, 8'h00, 1'b0, 15};
    vecs[1] = '{"bad_csum", 17'h00100, 7'h00, 0, 1'b0, 8'h01, 1'b1, 0};
    vecs[2] = '{"garbage",  17'h00100, 7'h00, 3, 1'b0, 8'h00, 1'b0, 15};
    vecs[3] = '{"gapped",   17'h00100, 7'h00, 0, 1'b1, 8'h00, 1'b0, 15};
    vecs[4] = '{"wrap_pad", 17'h1FFF8, 7'h55, 0, 1'b0, 8'h00, 1'b0, 15};
    vecs[5] = '{"ones_pad", 17'h0FFF0, 7'h7F, 1, 1'b0, 8'h00, 1'b0, 15};

    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    #12;
    check("reset_s_ready", 32'(s_ready), 32'd0);
    check("reset_c_we", 32'(c_we), 32'd0);
    check("reset_c_addr", 32'(c_addr), 32'd0);
    check("reset_c_in", 32'(c_in), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_state", 32'(state), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) run_frame(vecs[v], 0);

    // Abort coincident with payload byte 20.
    err0 = err_seen;
    wr0  = writes_seen;
    pulse_start();
    send_byte(HDR_BYTE, 1'b0, 1'b0);
    for (int j = 0; j < 20; j++) send_byte(8'(j * 7 + 3), 1'b0, 1'b0);
    send_byte(8'h42, 1'b0, 1'b1);
    @(negedge clk);
    check("abort_state", 32'(state), 32'(IDLE));
    check("abort_ready", 32'(s_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    check("abort_no_err", 32'(err_seen - err0), 32'd0);
    check("abort_no_write", 32'(writes_seen - wr0), 32'd0);
    @(posedge clk); #1;
    run_frame(vecs[0], 0);

    run_frame(vecs[0], 1);
    run_frame(vecs[0], 2);
    run_frame(vecs[4], 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Coefficient programming engine for the sectioned IIR lowpass filter. It receives a framed byte stream over a valid/ready handshake and assembles it into the full SOS coefficient set (3 per section) in an internal buffer. It checks the frame checksum and only then bursts the whole set into the filter's coefficient write port (c_we/c_addr/c_in). A corrupted or aborted frame never partially overwrites the filter's coefficient bank.

## Interface
- ORD, 10: filter order; NCOEFF = ORD/2*3 coefficients (15).
- COEFF_WH, 2: coefficient integer bits, sign included.
- COEFF_FR, 15: coefficient fraction bits; COEFF_W = COEFF_WH+COEFF_FR (17).
- AW, derived: $clog2(NCOEFF) (4); must match the filter's c_addr width.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin receiving a frame; ignored unless in IDLE.
- abort  in  1  returns to IDLE from HDR/PAYLOAD/CSUM; ignored in IDLE and WRITE.
- s_data  in  8  stream byte.
- s_valid  in  1  s_data valid.
- s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid && s_ready on a rising edge.
- c_we  out  1  coefficient write strobe to the filter.
- c_addr  out  AW  coefficient index 0..NCOEFF-1.
- c_in  out  COEFF_W  coefficient value.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last coefficient write.
- err  out  1  one-cycle pulse on checksum mismatch.

## Operation
- Frame format: header 0xA5, then NCOEFF×3 payload bytes (each coefficient little-endian, 3 bytes), then 1 checksum byte.
- Checksum rule: (sum of payload bytes + checksum byte) mod 256 == 0. The header is not included in the sum.
- Coefficient assembly: value = {b2, b1, b0}[COEFF_W-1:0]. The upper 24-COEFF_W bits of b2 are ignored.
- FSM states and transitions:
  - IDLE: s_ready=0. A start pulse moves to HDR and clears the byte counter, coefficient index and sum.
  - HDR: s_ready=1. An accepted 0xA5 moves to PAYLOAD. Any other accepted byte is discarded and the state stays HDR.
  - PAYLOAD: s_ready=1. Each accepted byte is added to the sum and shifted into the assembly register. On the 3rd byte of a coefficient, buf[idx] is written and idx increments. After idx reaches NCOEFF the state moves to CSUM.
  - CSUM: s_ready=1. On an accepted byte, a match moves to WRITE; a mismatch pulses err and moves to IDLE.
  - WRITE: s_ready=0. c_we=1 for exactly NCOEFF consecutive cycles, with c_addr=0,1,…,NCOEFF-1 and c_in=buf[c_addr]. After the last write, done pulses and the state moves to IDLE.
- abort has priority over a simultaneous byte transfer; that byte is consumed but discarded. abort causes no err pulse.
- start outside IDLE and abort in WRITE have no effect. WRITE always completes.
- The buffer holds the last received values. A failed frame may overwrite buffer entries, but never reaches c_we.

## Timing
- Reset values: s_ready=0, c_we=0, c_addr=0, c_in=0, busy=0, done=0, err=0, state=IDLE.
- All outputs are registered.
- start in cycle t gives s_ready=1 and busy=1 from cycle t+1.
- Checksum byte accepted at edge t gives c_we=1 (addr 0) in cycle t+1 and the last write (addr NCOEFF-1) in cycle t+NCOEFF.
- done=1 in cycle t+NCOEFF+1; busy=0 in that same cycle.
- Mismatch at edge t gives err=1 in cycle t+1, with s_ready=0 and busy=0 in that same cycle.
- Throughput: one byte per cycle when s_valid is held high. Stalls from s_valid=0 have no side effects.
- rst mid-operation (including during WRITE) deasserts c_we immediately and asynchronously. No done or err pulse follows.

## Structure
- Package iir_coeff_pkg holds the header constant 8'hA5, the state enum {IDLE, HDR, PAYLOAD, CSUM, WRITE}, and the NCOEFF/AW derivation shared with the filter top.
- Sub-module iir_coeff_buf: NCOEFF×COEFF_W register file with one write port (from PAYLOAD) and one read port (addressed by the WRITE counter). It has no reset.

## Test plan
- Nominal frame: coefficients k=0..14 with value 17'h00100+k, correct checksum → 15 consecutive c_we cycles, addresses 0..14, c_in=17'h00100..17'h0010E; done one cycle after the last write; err never asserted.
- Bad checksum: same frame with checksum+1 → err pulse one cycle after the checksum byte; c_we never asserted; busy=0.
- Garbage before header: bytes 0x00, 0xFF, 0x5A, then a valid frame → the three bytes are discarded; writes identical to the nominal case.
- Gapped stream: s_valid toggled 1/0 every cycle, plus a ready check → identical writes to the nominal case; no byte lost or duplicated.
- Abort at payload byte 20: assert abort → IDLE next cycle, no err, no c_we; a following nominal frame writes correctly.
- Edge cases: abort and start during WRITE are ignored (all 15 writes complete); rst asserted at the 5th write → c_we=0 and all outputs at reset values while rst is high.
